// File: rtl/tone_sequencer.sv
// Three-note tune player: drives half-period and enable of the square-wave tone
// generator, with a silent gap between notes, and reports BUSY/DONE upstream.
module tone_sequencer #(
  parameter int NOTE_CYCLES = 6250000,
  parameter int GAP_CYCLES  = 1250000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [1:0]  tune_sel,
  output logic [15:0] half_period,
  output logic        tone_en,
  output logic [1:0]  note_idx,
  output logic        busy,
  output logic        done
);

  localparam int MAX_CYCLES = (NOTE_CYCLES > GAP_CYCLES) ? NOTE_CYCLES : GAP_CYCLES;
  localparam int CNT_W      = ($clog2(MAX_CYCLES + 1) > 23) ? $clog2(MAX_CYCLES + 1) : 23;

  typedef enum logic [1:0] {
    IDLE,
    NOTE,
    GAP
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         tune_q, tune_d;
  logic [15:0]        half_q, half_d;
  logic               tone_en_q, tone_en_d;
  logic [1:0]         note_idx_q, note_idx_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Built-in tune ROM; the unused fourth note slot reads as silence.
  function automatic logic [15:0] rom(input logic [1:0] tune, input logic [1:0] idx);
    logic [15:0] hp;
    case ({tune, idx})
      4'b00_00: hp = 16'd12500;
      4'b00_01: hp = 16'd8333;
      4'b00_10: hp = 16'd6250;
      4'b01_00: hp = 16'd6250;
      4'b01_01: hp = 16'd8333;
      4'b01_10: hp = 16'd12500;
      4'b10_00: hp = 16'd12500;
      4'b10_01: hp = 16'd12500;
      4'b10_10: hp = 16'd6250;
      4'b11_00: hp = 16'd8333;
      4'b11_01: hp = 16'd6250;
      4'b11_10: hp = 16'd8333;
      default:  hp = 16'd0;
    endcase
    return hp;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      tune_q     <= '0;
      half_q     <= '0;
      tone_en_q  <= 1'b0;
      note_idx_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tune_q     <= tune_d;
      half_q     <= half_d;
      tone_en_q  <= tone_en_d;
      note_idx_q <= note_idx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tune_d     = tune_q;
    half_d     = half_q;
    tone_en_d  = tone_en_q;
    note_idx_d = note_idx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    // Abort keeps the latched tune; only reset clears it.
    if (abort) begin
      state_d    = IDLE;
      cnt_d      = '0;
      half_d     = '0;
      tone_en_d  = 1'b0;
      note_idx_d = '0;
      busy_d     = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d    = NOTE;
            tune_d     = tune_sel;
            note_idx_d = '0;
            cnt_d      = CNT_W'(NOTE_CYCLES - 1);
            tone_en_d  = 1'b1;
            busy_d     = 1'b1;
            half_d     = rom(tune_sel, 2'd0);
          end
        end
        NOTE: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else if (note_idx_q != 2'd2) begin
            state_d   = GAP;
            tone_en_d = 1'b0;
            cnt_d     = CNT_W'(GAP_CYCLES - 1);
          end else begin
            state_d    = IDLE;
            tone_en_d  = 1'b0;
            busy_d     = 1'b0;
            half_d     = '0;
            note_idx_d = '0;
            done_d     = 1'b1;
          end
        end
        GAP: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            state_d    = NOTE;
            note_idx_d = note_idx_q + 2'd1;
            half_d     = rom(tune_q, note_idx_q + 2'd1);
            tone_en_d  = 1'b1;
            cnt_d      = CNT_W'(NOTE_CYCLES - 1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign half_period = half_q;
  assign tone_en     = tone_en_q;
  assign note_idx    = note_idx_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Self-checking bench for tone_sequencer: directed scenarios plus random traffic,
// compared every cycle against a timeline model of the tune.
module tb_tone_sequencer;

  localparam int N     = 10;
  localparam int G     = 3;
  localparam int TOTAL = 3 * N + 2 * G;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [1:0]  tune_sel = 2'd0;
  logic [15:0] half_period;
  logic        tone_en;
  logic [1:0]  note_idx;
  logic        busy;
  logic        done;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  int rom [4][3] = '{'{12500, 8333, 6250},
                     '{6250, 8333, 12500},
                     '{12500, 12500, 6250},
                     '{8333, 6250, 8333}};

  // Model: whether a tune is playing, cycles elapsed since it started, which tune.
  bit m_play = 1'b0;
  int m_t    = 0;
  int m_tune = 0;
  bit m_done = 1'b0;

  always #5 clk = ~clk;

  tone_sequencer #(.NOTE_CYCLES(N), .GAP_CYCLES(G)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .tune_sel    (tune_sel),
    .half_period (half_period),
    .tone_en     (tone_en),
    .note_idx    (note_idx),
    .busy        (busy),
    .done        (done)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic modelStep();
    bit nd;
    nd = 1'b0;
    if (reset) begin
      m_play = 1'b0;
      m_tune = 0;
    end else if (abort) begin
      m_play = 1'b0;
    end else if (m_play) begin
      m_t++;
      if (m_t == TOTAL) begin
        m_play = 1'b0;
        nd     = 1'b1;
      end
    end else if (start) begin
      m_play = 1'b1;
      m_t    = 0;
      m_tune = int'(tune_sel);
    end
    m_done = nd;
  endtask

  task automatic compareAll();
    int p;
    int idx;
    int tone;
    int half;
    int bsy;
    idx = 0; tone = 0; half = 0; bsy = 0;
    if (m_play) begin
      p   = m_t;
      bsy = 1;
      for (int k = 0; k < 3; k++) begin
        if (p < N) begin
          idx = k; tone = 1;
          break;
        end
        p -= N;
        if (p < G) begin
          idx = k; tone = 0;
          break;
        end
        p -= G;
      end
      half = rom[m_tune][idx];
    end
    checkOutput("half_period", 32'(half_period), 32'(half));
    checkOutput("tone_en", 32'(tone_en), 32'(tone));
    checkOutput("note_idx", 32'(note_idx), 32'(idx));
    checkOutput("busy", 32'(busy), 32'(bsy));
    checkOutput("done", 32'(done), 32'(m_done));
  endtask

  task automatic applyStimulus(input bit r, input bit a, input bit s, input logic [1:0] ts);
    reset    = r;
    abort    = a;
    start    = s;
    tune_sel = ts;
    @(posedge clk);
    modelStep();
    #1;
    cyc++;
    compareAll();
  endtask

  task automatic runCycles(input int n, input bit s, input logic [1:0] ts);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, s, ts);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 2'd0);

    // Tune 0 played to completion
    applyStimulus(1'b0, 1'b0, 1'b1, 2'd0);
    runCycles(40, 1'b0, 2'd0);

    // Tune select latched at start, later changes ignored
    applyStimulus(1'b0, 1'b0, 1'b1, 2'd1);
    runCycles(15, 1'b0, 2'd1);
    runCycles(30, 1'b0, 2'd3);

    // Abort in the middle of the second note
    applyStimulus(1'b0, 1'b0, 1'b1, 2'd0);
    runCycles(N + G + 4, 1'b0, 2'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd0);
    runCycles(3, 1'b0, 2'd0);

    // Abort during the first gap
    applyStimulus(1'b0, 1'b0, 1'b1, 2'd3);
    runCycles(N + 1, 1'b0, 2'd3);
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd3);
    runCycles(3, 1'b0, 2'd3);

    // START held high: back-to-back restart on the DONE cycle
    runCycles(2 * TOTAL + 10, 1'b1, 2'd2);
    runCycles(TOTAL + 2, 1'b0, 2'd2);

    // START pulse mid-tune is ignored
    applyStimulus(1'b0, 1'b0, 1'b1, 2'd3);
    runCycles(5, 1'b0, 2'd3);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'd0);
    runCycles(TOTAL, 1'b0, 2'd0);

    // START and ABORT together in IDLE
    applyStimulus(1'b0, 1'b1, 1'b1, 2'd1);
    runCycles(2, 1'b0, 2'd1);

    // Reset mid-note of tune 2, then replay tune 2
    applyStimulus(1'b0, 1'b0, 1'b1, 2'd2);
    runCycles(15, 1'b0, 2'd2);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd2);
    runCycles(2, 1'b0, 2'd2);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'd2);
    runCycles(TOTAL + 2, 1'b0, 2'd2);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 249) == 0,
                    $urandom_range(0, 79) == 0,
                    $urandom_range(0, 5) == 0,
                    2'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tone_sequencer.md
# tone_sequencer

Plays a fixed three-note tune by driving the configuration inputs of the square-wave tone generator that feeds the 8-bit audio DAC. On a START request it latches one of four built-in tunes and steps through its notes. For each note it drives the tone half-period and enable for a fixed duration, then inserts a silent gap before the next note. It sits between the top-level control logic (switches, robot "done" event) and the tone generator, and reports BUSY/DONE back to the control logic.

## Interface
- NOTE_CYCLES, 6250000 — length of each note in CLK cycles (250 ms at 25 MHz).
- GAP_CYCLES, 1250000 — silent gap between notes in CLK cycles (50 ms); must be ≥ 1.
- CLK  in  1  — 25 MHz system clock; all logic on posedge.
- RESET  in  1  — synchronous, active-high reset.
- START  in  1  — request to play; sampled level, accepted only in IDLE.
- ABORT  in  1  — stop immediately; sampled level.
- TUNE_SEL  in  2  — tune index; sampled only on the cycle START is accepted.
- HALF_PERIOD  out  16  — tone half-period in CLK cycles, for the tone generator.
- TONE_EN  out  1  — tone generator enable; 1 = sound.
- NOTE_IDX  out  2  — current note index, 0..2.
- BUSY  out  1  — 1 while a tune is in progress.
- DONE  out  1  — one-cycle pulse on normal completion; does not pulse on abort.

## Operation
- The clock is one clock; reset is synchronous and active-high. All outputs are registered.
- Reset values: state IDLE, HALF_PERIOD=0, TONE_EN=0, NOTE_IDX=0, BUSY=0, DONE=0, duration counter=0, latched tune=0.
- Tune ROM (half-periods; 12500=1 kHz, 8333≈1.5 kHz, 6250=2 kHz):
  - tune 0: 12500, 8333, 6250
  - tune 1: 6250, 8333, 12500
  - tune 2: 12500, 12500, 6250
  - tune 3: 8333, 6250, 8333
- FSM states: IDLE, NOTE, GAP.
- IDLE, START=1, ABORT=0:
  - Latch TUNE_SEL and set NOTE_IDX=0.
  - Load the counter with NOTE_CYCLES-1 and go to NOTE.
  - Set TONE_EN=1, BUSY=1, HALF_PERIOD=ROM[tune][0].
- NOTE, counter≠0: decrement the counter.
- NOTE, counter=0 and NOTE_IDX<2: go to GAP with TONE_EN=0 and the counter loaded with GAP_CYCLES-1. HALF_PERIOD holds the current note's value.
- NOTE, counter=0 and NOTE_IDX=2: go to IDLE with TONE_EN=0, BUSY=0, HALF_PERIOD=0, NOTE_IDX=0 and DONE=1 for that one cycle.
- GAP, counter≠0: decrement the counter.
- GAP, counter=0: go to NOTE with NOTE_IDX+1, HALF_PERIOD=ROM[tune][NOTE_IDX+1], TONE_EN=1 and the counter loaded with NOTE_CYCLES-1.
- Priority: RESET > ABORT > START/counter events.
- ABORT in any state: next state IDLE, with all outputs at their reset values (DONE=0).
- START while BUSY=1 is ignored. A TUNE_SEL change mid-tune has no effect.
- START in the IDLE cycle where DONE=1 is accepted, giving a back-to-back restart.
- START and ABORT high together in IDLE: ABORT wins and the block stays IDLE.
- Counter width: 23 bits minimum (≥ ceil(log2(max(NOTE_CYCLES, GAP_CYCLES)))). Arithmetic is unsigned and never wraps.

## Timing
- START is sampled at edge k; BUSY, TONE_EN, HALF_PERIOD and NOTE_IDX are valid after edge k (1-cycle latency).
- TONE_EN is high for exactly NOTE_CYCLES consecutive cycles per note and low for exactly GAP_CYCLES cycles between notes.
- Total BUSY time is 3·NOTE_CYCLES + 2·GAP_CYCLES cycles.
- DONE rises on the same edge that BUSY falls, and lasts 1 cycle.
- ABORT at edge k: TONE_EN=0 and BUSY=0 after edge k.
- RESET mid-tune behaves identically to ABORT, and additionally clears the latched tune.

## Test plan
- **Tune 0, normal play.** Setup: NOTE_CYCLES=10, GAP_CYCLES=3, TUNE_SEL=0, 1-cycle START.
  - HALF_PERIOD sequence: 12500 (10 cycles), gap (3), 8333 (10), gap (3), 6250 (10).
  - BUSY high for 36 cycles; DONE pulses once as BUSY falls.
- **Tune select latch.** TUNE_SEL=1 at START, then changed to 3 mid-tune -> notes are 6250, 8333, 12500 throughout.
- **Abort mid-note and mid-gap.**
  - ABORT at cycle 5 of note 1 -> next cycle TONE_EN=0, BUSY=0, HALF_PERIOD=0, no DONE pulse.
  - Repeat with ABORT during a gap -> same result.
- **START handling.**
  - START held high for the whole tune -> exactly one tune per acceptance; the tune restarts on the DONE cycle with NOTE_IDX=0.
  - A START pulse mid-tune has no effect.
- **Simultaneous START+ABORT in IDLE** -> stays IDLE, all outputs 0.
- **Reset.** RESET asserted mid-note of tune 2 -> all outputs at reset values the following cycle; a subsequent START with TUNE_SEL=2 plays 12500, 12500, 6250 from note 0.
